trap_ctrl: RTL



---
 rtl/trap_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: picks exception / MRET / interrupt at writeback,
// strobes the CSR file, flushes, and hands a redirect PC to fetch. TRAP_CTRL_VECTORED_EN enables vectored interrupt targets.
module trap_ctrl #(
    parameter int unsigned HOLDOFF_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        exc_valid,
    input  logic [3:0]  exc_cause,
    input  logic        mret_req,
    input  logic        eip,
    input  logic        tip,
    input  logic        sip,
    input  logic [31:0] trap_vector,
    input  logic [31:0] mret_vector,
    input  logic        redirect_ready,
    output logic        wb_kill,
    output logic        traped,
    output logic        mret,
    output logic [31:0] ecp,
    output logic [3:0]  trap_cause,
    output logic        interupt,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, COMMIT, REDIRECT, HOLDOFF} state_t;

    state_t      state_reg;
    logic [3:0]  holdoff_reg;

    logic        take_exc;
    logic        take_mret;
    logic        take_irq;
    logic [3:0]  irq_cause;
    logic [31:0] irq_target;

    // Fixed priority: exception, then MRET, then eip > sip > tip.
    assign take_exc  = wb_valid && exc_valid;
    assign take_mret = wb_valid && !exc_valid && mret_req;
    assign take_irq  = wb_valid && !exc_valid && !mret_req
                       && (eip || sip || tip) && (holdoff_reg == 4'd0);

    always_comb begin
        irq_cause = 4'd7;
        if (eip)
            irq_cause = 4'd11;
        else if (sip)
            irq_cause = 4'd3;
    end

`ifdef TRAP_CTRL_VECTORED_EN
    assign irq_target = trap_vector + {26'd0, irq_cause, 2'b00};
`else
    assign irq_target = trap_vector;
`endif

    assign wb_kill = (state_reg == IDLE) && (take_exc || take_mret || take_irq);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            holdoff_reg    <= 4'd0;
            traped         <= 1'b0;
            mret           <= 1'b0;
            ecp            <= 32'd0;
            trap_cause     <= 4'd0;
            interupt       <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            busy           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (wb_kill) begin
                        ecp       <= wb_pc;
                        flush     <= 1'b1;
                        busy      <= 1'b1;
                        state_reg <= COMMIT;
                        if (take_exc) begin
                            trap_cause  <= exc_cause;
                            interupt    <= 1'b0;
                            redirect_pc <= trap_vector;
                            traped      <= 1'b1;
                        end else if (take_mret) begin
                            redirect_pc <= mret_vector;
                            mret        <= 1'b1;
                        end else begin
                            trap_cause  <= irq_cause;
                            interupt    <= 1'b1;
                            redirect_pc <= irq_target;
                            traped      <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    traped         <= 1'b0;
                    mret           <= 1'b0;
                    redirect_valid <= 1'b1;
                    state_reg      <= REDIRECT;
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        flush          <= 1'b0;
                        holdoff_reg    <= 4'(HOLDOFF_CYCLES);
                        if (HOLDOFF_CYCLES == 0) begin
                            busy      <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            state_reg <= HOLDOFF;
                        end
                    end
                end
                HOLDOFF: begin
                    // Leaving on the count of 1 lands the counter at 0 in IDLE.
                    if (holdoff_reg <= 4'd1) begin
                        holdoff_reg <= 4'd0;
                        busy        <= 1'b0;
                        state_reg   <= IDLE;
                    end else begin
                        holdoff_reg <= holdoff_reg - 4'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
